mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between two requesters of the pipelined MIPS core: the fetch stage (I port) and the memory stage (D port).
- Sequences one access at a time over a req/ack memory handshake and returns per-port ready pulses. The core's hazard unit uses these pulses to stall F and M.
- Data has priority over fetch, with a bounded-starvation guard for fetch.
- A watchdog flags a memory that never acknowledges.

Parameters:
- MAXD, 4: maximum consecutive D grants made while I is waiting; after this many, the next grant goes to I.
- TIMEOUT, 64: cycles a granted access may wait for memack before err is set.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ireq  in  1  fetch request; level, held until iready.
- iaddr  in  32  fetch byte address.
- irdata  out  32  fetch read data; valid only while iready=1.
- iready  out  1  one-cycle pulse: fetch access complete.
- dreq  in  1  data request; level, held until dready.
- dwe  in  1  1=store, 0=load; qualified by dreq.
- daddr  in  32  data byte address.
- dwdata  in  32  store data.
- drdata  out  32  load data; valid only while dready=1.
- dready  out  1  one-cycle pulse: data access complete.
- memreq  out  1  access request to memory.
- memwe  out  1  write enable to memory.
- memaddr  out  32  address to memory.
- memwdata  out  32  write data to memory.
- memrdata  in  32  memory read data; valid with memack.
- memack  in  1  one-cycle pulse: memory access done.
- err  out  1  sticky timeout flag.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, plus a registered copy of the granted address, write enable and write data.
- Reset (synchronous, takes priority over all else):
  - state=IDLE, fairness count=0, watchdog=0, err=0.
  - memreq=0, memwe=0, memaddr=0, memwdata=0, iready=0, dready=0.
- IDLE, arbitration each cycle:
  - dreq & (~ireq | cnt<MAXD) → BUSY_D. Latch daddr, dwe, dwdata.
  - Otherwise ireq → BUSY_I. Latch iaddr; memwe=0.
  - Otherwise stay in IDLE.
- Grant is registered, so memreq rises the cycle after the request is seen.
- Fairness count:
  - On a D grant with ireq=1: cnt=min(cnt+1, MAXD).
  - On a D grant with ireq=0: cnt=0.
  - On an I grant: cnt=0.
- BUSY_x:
  - memreq=1 and memaddr/memwe/memwdata come from the latched values; they stay constant for the whole access.
  - memack=1 → x-ready=1 combinationally in that same cycle. x-rdata=memrdata (pass-through; drdata is still driven on stores but is don't-care). Next state is IDLE.
  - Minimum turnaround: grant cycle, then ≥1 BUSY cycle, then IDLE. Back-to-back accesses are therefore separated by one IDLE cycle.
- Request protocol:
  - A requester holds req and its operands stable until its ready pulse.
  - If req is still high in the cycle after ready, it is a new request.
  - Changing operands while waiting is illegal; the arbiter uses the latched copy.
- memack in IDLE is ignored.
- iready and dready are never asserted in the same cycle.
- Watchdog:
  - Counts cycles spent in BUSY_x and clears on every entry to BUSY_x.
  - When the count reaches TIMEOUT without memack: err=1 (sticky until reset) and state is forced to IDLE with no ready pulse. The requester re-arbitrates.
- Reset mid-access: memreq drops the next cycle and the access is abandoned; a later memack is ignored as in IDLE.
- Simultaneous events:
  - dreq and ireq rising together with cnt=0 → D wins.
  - memack coinciding with the watchdog limit → the ack wins; ready pulses and err stays 0.

Test Plan:
- Fetch only: ireq=1, iaddr=0x00000040, memack 2 cycles after memreq, memrdata=0x20020005 → memaddr=0x40, memwe=0; iready pulses once with irdata=0x20020005; the next memreq to 0x40 follows one IDLE cycle later.
- Contention: ireq and dreq rise in the same cycle, dwe=1, daddr=0x54, dwdata=7 → first access memwe=1, memaddr=0x54, memwdata=7, dready pulses; the next grant goes to I.
- Starvation guard, MAXD=4: dreq and ireq held high continuously → D, D, D, D, I, D, …; exactly 4 dready pulses precede each iready.
- Timeout, TIMEOUT=64: dreq=1 with memack never asserted → err=1 after 64 BUSY cycles, state returns to IDLE, no dready; err stays 1 until reset.
- Reset mid-access: assert reset during BUSY_I, then pulse memack one cycle after reset is released → memreq=0 after the reset edge; no iready; err=0.
- Stray ack: memack pulse in IDLE with no requests → no ready pulses, memreq stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one req/ack memory between the fetch (I) and data (D) ports with D priority, bounded I starvation and an ack watchdog
module mem_arbiter #(
    parameter int MAXD    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq,
    input  logic [31:0] iaddr,
    output logic [31:0] irdata,
    output logic        iready,
    input  logic        dreq,
    input  logic        dwe,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    output logic [31:0] drdata,
    output logic        dready,
    output logic        memreq,
    output logic        memwe,
    output logic [31:0] memaddr,
    output logic [31:0] memwdata,
    input  logic [31:0] memrdata,
    input  logic        memack,
    output logic        err
);
    localparam int CW = $clog2(MAXD + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] MAXD_C  = CW'(MAXD);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
    logic [31:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;

    // arbitration in IDLE, completion or watchdog expiry while busy
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        err_d   = err_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        if (state_q == IDLE) begin
            wd_d = '0;
            if (dreq && (!ireq || cnt_q < MAXD_C)) begin
                state_d = BUSY_D;
                addr_d  = daddr;
                we_d    = dwe;
                wdata_d = dwdata;
                cnt_d   = ireq ? ((cnt_q < MAXD_C) ? cnt_q + CW'(1) : MAXD_C) : '0;
            end else if (ireq) begin
                state_d = BUSY_I;
                addr_d  = iaddr;
                we_d    = 1'b0;
                cnt_d   = '0;
            end
        end else if (memack) begin
            state_d = IDLE;
        end else if (wd_q == WD_LAST) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else begin
            wd_d = wd_q + WW'(1);
        end
    end

    // state, fairness, watchdog and latched access registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    assign memreq   = state_q != IDLE;
    assign memwe    = memreq && we_q;
    assign memaddr  = addr_q;
    assign memwdata = wdata_q;
    assign iready   = state_q == BUSY_I && memack;
    assign dready   = state_q == BUSY_D && memack;
    assign irdata   = memrdata;
    assign drdata   = memrdata;
    assign err      = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter with a memory responder and a transaction-level reference
module tb_mem_arbiter;
    localparam int MAXD    = 4;
    localparam int TIMEOUT = 64;

    logic        clk, reset;
    logic        ireq, dreq, dwe, memack;
    logic [31:0] iaddr, daddr, dwdata, memrdata;
    logic [31:0] irdata, drdata, memaddr, memwdata;
    logic        iready, dready, memreq, memwe, err;

    mem_arbiter #(.MAXD(MAXD), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .iready(iready),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .drdata(drdata), .dready(dready),
        .memreq(memreq), .memwe(memwe), .memaddr(memaddr), .memwdata(memwdata),
        .memrdata(memrdata), .memack(memack), .err(err)
    );

    typedef struct packed {
        logic [31:0] a;
        logic        we;
        logic [31:0] wd;
        logic [31:0] rd;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    exp_t        iq[$];
    exp_t        dq[$];
    byte         order_q[$];
    logic [31:0] dmem[logic [31:0]];
    logic [31:0] ref_dmem[logic [31:0]];
    int          fixed_lat = 2;
    bit          ack_en = 1;
    bit          stray = 0;
    int          wait_cnt = 0;
    exp_t        me;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL sim_limit: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_dmem.exists(a) ? ref_dmem[a] : init_val(a);
    endfunction

    // memory responder: acks after a programmable latency, or pulses a stray ack on demand
    initial begin
        memack   = 1'b0;
        memrdata = '0;
        forever begin
            @(posedge clk);
            #1;
            memack = 1'b0;
            if (stray) begin
                memack   = 1'b1;
                memrdata = $urandom;
            end else if (!memreq) begin
                wait_cnt = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 3));
            end else if (ack_en) begin
                if (wait_cnt == 0) begin
                    memack   = 1'b1;
                    memrdata = memwe ? $urandom : mem_rd(memaddr);
                    if (memwe) dmem[memaddr] = memwdata;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // monitor: pops the scoreboard on every ready pulse
    always @(negedge clk) begin
        if (iready) begin
            if (iq.size() == 0) chk("unexpected_iready", {31'b0, iready}, 32'd0);
            else begin
                me = iq.pop_front();
                chk("irdata", irdata, me.rd);
                chk("i_memaddr", memaddr, me.a);
                chk("i_memwe", {31'b0, memwe}, 32'd0);
                chk("i_excl", {31'b0, dready}, 32'd0);
                order_q.push_back("I");
            end
        end
        if (dready) begin
            if (dq.size() == 0) chk("unexpected_dready", {31'b0, dready}, 32'd0);
            else begin
                me = dq.pop_front();
                chk("d_memaddr", memaddr, me.a);
                chk("d_memwe", {31'b0, memwe}, {31'b0, me.we});
                if (me.we) chk("d_memwdata", memwdata, me.wd);
                else chk("drdata", drdata, me.rd);
                order_q.push_back("D");
            end
        end
    end

    task automatic i_op(input logic [31:0] a, input bit hold);
        exp_t e;
        bit   got;
        ireq  = 1'b1;
        iaddr = a;
        e     = '{a: a, we: 1'b0, wd: 32'd0, rd: ref_rd(a)};
        iq.push_back(e);
        got = 0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            got = iready;
        end
        if (!got) begin
            chk("iready_wait", {31'b0, got}, 32'd1);
            void'(iq.pop_back());
        end
        @(posedge clk);
        #1;
        if (!hold) ireq = 1'b0;
    endtask

    task automatic d_op(input logic [31:0] a, input bit we, input logic [31:0] wd, input bit hold);
        exp_t e;
        bit   got;
        dreq   = 1'b1;
        daddr  = a;
        dwe    = we;
        dwdata = wd;
        e      = '{a: a, we: we, wd: wd, rd: we ? 32'd0 : ref_rd(a)};
        if (we) ref_dmem[a] = wd;
        dq.push_back(e);
        got = 0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            got = dready;
        end
        if (!got) begin
            chk("dready_wait", {31'b0, got}, 32'd1);
            void'(dq.pop_back());
        end
        @(posedge clk);
        #1;
        if (!hold) dreq = 1'b0;
    endtask

    function automatic logic [31:0] rnd_daddr();
        return 32'h1000 + (32'($urandom_range(0, 7)) << 2);
    endfunction

    initial begin
        byte exp_order[$];
        int  nd, ni, streak, n;
        bit  got, done;
        reset = 1'b1; ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
        iaddr = '0; daddr = '0; dwdata = '0;
        dmem[32'h40]     = 32'h2002_0005;
        ref_dmem[32'h40] = 32'h2002_0005;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_memreq", {31'b0, memreq}, 32'd0);
        chk("rst_memwe", {31'b0, memwe}, 32'd0);
        chk("rst_memaddr", memaddr, 32'd0);
        chk("rst_memwdata", memwdata, 32'd0);
        chk("rst_iready", {31'b0, iready}, 32'd0);
        chk("rst_dready", {31'b0, dready}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // fetch only, held across the ready pulse
        i_op(32'h40, 1'b1);
        @(negedge clk);
        chk("idle_gap_memreq", {31'b0, memreq}, 32'd0);
        @(negedge clk);
        chk("refetch_memreq", {31'b0, memreq}, 32'd1);
        chk("refetch_memaddr", memaddr, 32'h40);
        chk("refetch_memwe", {31'b0, memwe}, 32'd0);
        i_op(32'h40, 1'b0);

        // contention: D wins with count 0, then I
        order_q.delete();
        fork
            d_op(32'h54, 1'b1, 32'd7, 1'b0);
            i_op(32'h80, 1'b0);
        join
        chk("contention_len", order_q.size(), 32'd2);
        if (order_q.size() == 2) begin
            chk("contention_first", {24'b0, order_q[0]}, {24'b0, 8'("D")});
            chk("contention_second", {24'b0, order_q[1]}, {24'b0, 8'("I")});
        end

        // starvation guard with both requests held
        fixed_lat = -1;
        order_q.delete();
        fork
            for (int k = 0; k < 10; k++) d_op(rnd_daddr(), 1'($urandom_range(0, 1)), $urandom, k < 9);
            for (int k = 0; k < 3; k++) i_op(32'h40 + (32'(k) << 2), k < 2);
        join
        nd = 10; ni = 3; streak = 0;
        while (nd > 0 || ni > 0) begin
            if (nd > 0 && (ni == 0 || streak < MAXD)) begin
                exp_order.push_back("D");
                nd--;
                streak = ni > 0 ? streak + 1 : 0;
            end else begin
                exp_order.push_back("I");
                ni--;
                streak = 0;
            end
        end
        chk("starve_len", order_q.size(), exp_order.size());
        for (int k = 0; k < exp_order.size() && k < order_q.size(); k++)
            chk("starve_order", {24'b0, order_q[k]}, {24'b0, exp_order[k]});

        // random mixed traffic
        fork
            for (int k = 0; k < 15; k++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                i_op(32'h40 + (32'($urandom_range(0, 15)) << 2), 1'b0);
            end
            for (int k = 0; k < 20; k++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                d_op(rnd_daddr(), 1'($urandom_range(0, 1)), $urandom, 1'b0);
            end
        join

        // ack on the last watchdog cycle still completes
        fixed_lat = TIMEOUT - 1;
        d_op(32'h1004, 1'b0, 32'd0, 1'b0);
        chk("ack_at_limit_err", {31'b0, err}, 32'd0);
        fixed_lat = -1;

        // stray ack in IDLE
        @(posedge clk);
        #1;
        stray = 1'b1;
        @(negedge clk);
        chk("stray_iready", {31'b0, iready}, 32'd0);
        chk("stray_dready", {31'b0, dready}, 32'd0);
        chk("stray_memreq", {31'b0, memreq}, 32'd0);
        @(posedge clk);
        #1;
        stray = 1'b0;

        // reset in the middle of a fetch
        ack_en = 1'b0;
        ireq   = 1'b1;
        iaddr  = 32'h48;
        got    = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            got = memreq;
        end
        chk("midrst_grant", {31'b0, got}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        ireq  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_memreq", {31'b0, memreq}, 32'd0);
        @(posedge clk);
        #1;
        stray = 1'b1;
        @(posedge clk);
        #1;
        stray = 1'b0;
        @(negedge clk);
        chk("midrst_err", {31'b0, err}, 32'd0);
        chk("midrst_memreq_late", {31'b0, memreq}, 32'd0);

        // watchdog timeout on a load that never gets acked
        dreq  = 1'b1;
        daddr = 32'h1008;
        dwe   = 1'b0;
        n     = 0;
        done  = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (memreq) begin
                n++;
                if (n == TIMEOUT - 1) chk("err_before_limit", {31'b0, err}, 32'd0);
            end else if (n > 0) done = 1;
        end
        dreq = 1'b0;
        chk("timeout_busy_cycles", n, TIMEOUT);
        chk("timeout_err", {31'b0, err}, 32'd1);
        chk("timeout_memreq", {31'b0, memreq}, 32'd0);
        repeat (3) @(negedge clk);
        chk("err_sticky", {31'b0, err}, 32'd1);
        @(posedge clk);
        #1;
        ack_en = 1'b1;
        i_op(32'h44, 1'b0);
        chk("err_sticky_after_access", {31'b0, err}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("err_cleared", {31'b0, err}, 32'd0);
        chk("final_iq_empty", iq.size(), 32'd0);
        chk("final_dq_empty", dq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
